// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch controller:
//     fetch_state_e : controller states (RUN streams from memory, HOLD replays
//                     a captured instruction while decode is stalled)
//     PC_STEP       : default byte increment between sequential fetches
//     align_word    : clears the byte-offset bits of an address
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction fetch front end for a synchronous-read instruction memory.
//   The memory returns data one cycle after it samples imem_addr, so the
//   controller always runs one address ahead of the instruction it presents.
//   When decode stalls, the presented instruction is parked in a hold
//   register so the memory can keep reading the next address; on release the
//   parked instruction's successor is already on the memory output.
//
// Parameters
//   RESET_PC : first fetch address after reset (word aligned)
//   PC_STEP  : byte increment between sequential fetches
//
// Ports
//   clk         in   single clock, all state changes on the rising edge
//   reset       in   synchronous active-high reset
//   stall       in   decode cannot accept the presented instruction
//   redirect    in   taken branch/jump, discard the current stream
//   redirect_pc in   redirect target byte address (low bits ignored)
//   imem_addr   out  byte address to the instruction memory
//   imem_instr  in   memory read data, one cycle after imem_addr
//   if_pc       out  PC of the presented instruction
//   if_instr    out  presented instruction
//   if_valid    out  presented instruction is valid; consumed if !stall
//   misaligned  out  one-cycle pulse after a redirect with redirect_pc[1:0]!=0
// ----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = fetch_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid,
    output logic        misaligned
);

    fetch_pkg::fetch_state_e state_q, state_d;

    logic [31:0] fetch_pc_q,   fetch_pc_d;    // address being read this cycle
    logic [31:0] resp_pc_q,    resp_pc_d;     // address of data on imem_instr
    logic        resp_vld_q,   resp_vld_d;
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] redirect_aligned;

    assign redirect_aligned = fetch_pkg::align_word(redirect_pc);

    // Reset forces the memory address so the first read after release is
    // already at RESET_PC, independent of any redirect in the same cycle.
    always_comb begin
        if (reset) begin
            imem_addr = RESET_PC;
        end else if (redirect) begin
            imem_addr = redirect_aligned;
        end else begin
            imem_addr = fetch_pc_q;
        end
    end

    // Presentation: RUN forwards memory data, HOLD replays the parked copy.
    // A redirect kills whatever is presented in its own cycle.
    always_comb begin
        if (state_q == fetch_pkg::HOLD) begin
            if_instr = hold_instr_q;
            if_pc    = hold_pc_q;
            if_valid = !redirect && !reset;
        end else begin
            if_instr = imem_instr;
            if_pc    = resp_pc_q;
            if_valid = resp_vld_q && !redirect && !reset;
        end
    end

    assign misaligned = misaligned_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        resp_pc_d    = resp_pc_q;
        resp_vld_d   = resp_vld_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        misaligned_d = 1'b0;

        if (redirect) begin
            // The target is read this cycle, so it is presented next cycle.
            state_d      = fetch_pkg::RUN;
            resp_pc_d    = redirect_aligned;
            resp_vld_d   = 1'b1;
            fetch_pc_d   = redirect_aligned + PC_STEP;
            misaligned_d = |redirect_pc[1:0];
        end else if (state_q == fetch_pkg::RUN) begin
            if (!stall) begin
                resp_pc_d  = fetch_pc_q;
                resp_vld_d = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else if (resp_vld_q) begin
                // Park the stalled instruction; the memory keeps reading
                // fetch_pc, which becomes the next instruction to present.
                hold_instr_d = imem_instr;
                hold_pc_d    = resp_pc_q;
                resp_pc_d    = fetch_pc_q;
                state_d      = fetch_pkg::HOLD;
            end else begin
                resp_vld_d = 1'b0;
            end
        end else begin
            // HOLD: memory output already carries data for fetch_pc (and
            // resp_pc matches it), so leaving HOLD only advances fetch_pc.
            if (!stall) begin
                state_d    = fetch_pkg::RUN;
                resp_vld_d = 1'b1;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= fetch_pkg::RUN;
            fetch_pc_q   <= RESET_PC;
            resp_pc_q    <= 32'd0;
            resp_vld_q   <= 1'b0;
            hold_pc_q    <= 32'd0;
            hold_instr_q <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_vld_q   <= resp_vld_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Drives imem_fetch_ctrl against a synchronous-read memory whose contents
//   are a fixed function of the address. A stream-level model tracks which
//   PC must be presented next and when the output must be valid; it is
//   checked every cycle. Directed sequences add literal expectations, then a
//   randomized run mixes stalls, redirects (incl. misaligned/wrapping) and
//   resets.
// ----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h0000_1234;
    endfunction

    // Instruction memory: data appears one cycle after the address.
    always @(posedge clk) imem_instr <= mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stream-level reference model, evaluated at each falling edge.
    //   next_pc   : PC the DUT owes decode next
    //   valid is owed unless reset/redirect now, or this is the first cycle
    //   after reset, or the previous cycle was an empty cycle that stalled.
    // ------------------------------------------------------------------
    logic        m_prev_reset    = 1'b1;
    logic        m_prev_redirect = 1'b0;
    logic        m_prev_valid    = 1'b0;
    logic        m_prev_stall    = 1'b0;
    logic        m_prev_misal    = 1'b0;
    logic [31:0] m_next_pc       = RESET_PC;

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = !reset && !redirect && !m_prev_reset &&
                    (m_prev_redirect || m_prev_valid || !m_prev_stall);

        chk("model_valid", {31'd0, if_valid}, {31'd0, exp_valid});
        chk("model_misaligned", {31'd0, misaligned}, {31'd0, m_prev_misal});
        if (exp_valid) begin
            chk("model_pc", if_pc, m_next_pc);
            chk("model_instr", if_instr, mem_word(m_next_pc));
        end
        if (reset) begin
            chk("model_addr_rst", imem_addr, RESET_PC);
        end else if (redirect) begin
            chk("model_addr_redir", imem_addr, {redirect_pc[31:2], 2'b00});
        end

        m_prev_misal = !reset && redirect && (redirect_pc[1:0] != 2'b00);
        if (reset) begin
            m_next_pc       = RESET_PC;
            m_prev_reset    = 1'b1;
            m_prev_valid    = 1'b0;
            m_prev_redirect = 1'b0;
            m_prev_stall    = 1'b0;
        end else begin
            if (redirect) begin
                m_next_pc = {redirect_pc[31:2], 2'b00};
            end else if (exp_valid && !stall) begin
                m_next_pc = m_next_pc + 32'd4;
            end
            m_prev_reset    = 1'b0;
            m_prev_valid    = exp_valid;
            m_prev_redirect = redirect;
            m_prev_stall    = stall;
        end
    end

    // One cycle: drive inputs just after the rising edge, return at the
    // falling edge so literal checks see settled outputs.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] p);
        @(posedge clk);
        #1;
        reset       = r;
        stall       = s;
        redirect    = d;
        redirect_pc = p;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp_pc);
        chk({name, "_valid"}, {31'd0, if_valid}, 32'd1);
        chk({name, "_pc"}, if_pc, exp_pc);
    endtask

    initial begin
        logic [31:0] saved;
        logic        r, s, d;
        logic [31:0] p;

        // Reset release, free-running stream 0,4,8,12.
        step(1, 0, 0, 0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("bubble_addr", imem_addr, 32'h0);
        chk("bubble_misaligned", {31'd0, misaligned}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            chk_pc("seq", 32'(i * 4));
            chk("seq_instr", if_instr, mem_word(32'(i * 4)));
        end

        // Three-cycle stall while pc=4.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_pc("st_pc0", 32'h0);
        step(0, 1, 0, 0);
        chk_pc("st_first", 32'h4);
        saved = if_instr;
        step(0, 1, 0, 0);
        chk_pc("st_hold1", 32'h4);
        chk("st_hold1_instr", if_instr, saved);
        step(0, 1, 0, 0);
        chk_pc("st_hold2", 32'h4);
        chk("st_hold2_instr", if_instr, saved);
        step(0, 0, 0, 0);
        chk_pc("st_release", 32'h4);
        chk("st_release_instr", if_instr, saved);
        step(0, 0, 0, 0);
        chk_pc("st_after8", 32'h8);
        step(0, 0, 0, 0);
        chk_pc("st_after12", 32'hC);

        // Redirect to 0x40 while pc=8.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        chk("rd_bubble", {31'd0, if_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h40);
        step(0, 0, 0, 0);
        chk_pc("rd_tgt", 32'h40);
        step(0, 0, 0, 0);
        chk_pc("rd_tgt4", 32'h44);

        // Redirect plus stall during HOLD.
        step(0, 1, 0, 0);
        chk_pc("hr_stall", 32'h48);
        step(0, 1, 1, 32'h80);
        chk("hr_bubble", {31'd0, if_valid}, 32'd0);
        step(0, 1, 0, 0);
        chk_pc("hr_tgt", 32'h80);
        step(0, 0, 0, 0);
        chk_pc("hr_tgt_again", 32'h80);
        step(0, 0, 0, 0);
        chk_pc("hr_tgt4", 32'h84);

        // Misaligned redirect.
        step(0, 0, 1, 32'h42);
        chk("mis_addr", imem_addr, 32'h40);
        step(0, 0, 0, 0);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk_pc("mis_tgt", 32'h40);
        step(0, 0, 0, 0);
        chk("mis_clear", {31'd0, misaligned}, 32'd0);
        chk_pc("mis_tgt4", 32'h44);

        // 32-bit wrap.
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk_pc("wrap_top", 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk_pc("wrap_zero", 32'h0);

        // Reset during HOLD.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk_pc("rh_hold", 32'h4);
        step(1, 1, 0, 0);
        chk("rh_rst_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("rh_after_valid", {31'd0, if_valid}, 32'd0);
        chk("rh_after_addr", imem_addr, RESET_PC);
        step(0, 0, 0, 0);
        chk_pc("rh_restart", RESET_PC);

        // Reset coincident with redirect.
        step(1, 0, 1, 32'h100);
        chk("rr_addr", imem_addr, RESET_PC);
        step(0, 0, 0, 0);
        chk("rr_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk_pc("rr_restart", RESET_PC);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 99) < 1);
            s = ($urandom_range(0, 99) < 30);
            d = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       p = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1:       p = 32'($urandom_range(0, 4095));
                default: p = {$urandom_range(0, 255) * 16} & 32'hFFFF_FFFC;
            endcase
            step(r, s, d, p);
        end

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
